// File: rtl/adder_sched.sv
// adder_sched: round-robin scheduler sharing one external 8-bit adder between
// NUM_REQ requesters. The winner's operands are registered onto add_a/add_b,
// add_sum is captured one cycle later, and the result is returned with the
// requester ID over a valid/ready response channel. One operation in flight.
//
// Build option: define ADDER_SCHED_CARRY_EN to capture the adder carry-out into
// rsp_carry; otherwise rsp_carry is tied to 0.
module adder_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  input  logic [7:0]           add_sum,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_sum,
  output logic                 rsp_carry,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StAdd, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic [ID_W:0]   cand;
  logic            found;
  logic            grant;
  logic [7:0]      sel_a, sel_b;
  logic [7:0]      add_a_q, add_b_q, rsp_sum_q;
  logic [ID_W-1:0] rsp_id_q;
  logic            rsp_valid_q;

  // Round-robin search: first valid requester above last, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    winner = '0;
    sel_a = '0;
    sel_b = '0;
    cand = '0;
    idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      idx = cand[ID_W-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        winner = idx;
        sel_a = req_a[8*idx +: 8];
        sel_b = req_b[8*idx +: 8];
      end
    end
  end

  // Next-state and grant; req_ready is only offered in idle and out of reset.
  always_comb begin
    state_d = state_q;
    req_ready = '0;
    grant = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found && wb_rst_ni) begin
          req_ready[winner] = 1'b1;
          grant = 1'b1;
          state_d = StAdd;
        end
      end
      StAdd: state_d = StResp;
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, pointer and response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_valid_q <= 1'b0;
      last_q      <= ID_W'(NUM_REQ - 1);
    end else begin
      if (grant) begin
        add_a_q  <= sel_a;
        add_b_q  <= sel_b;
        rsp_id_q <= winner;
        last_q   <= winner;
      end
      if (state_q == StAdd) begin
        rsp_sum_q   <= add_sum;
        rsp_valid_q <= 1'b1;
      end else if (state_q == StResp && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ADDER_SCHED_CARRY_EN
  logic rsp_carry_q;

  // Carry-out recovered from the operand MSBs and the sum MSB.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rsp_carry_q <= 1'b0;
    end else if (state_q == StAdd) begin
      rsp_carry_q <= (add_a_q[7] & add_b_q[7]) | ((add_a_q[7] | add_b_q[7]) & ~add_sum[7]);
    end
  end

  assign rsp_carry = rsp_carry_q;
`else
  assign rsp_carry = 1'b0;
`endif

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_adder_sched.sv
// Testbench for adder_sched: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level model of the scheduler.
module tb_adder_sched;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
`ifdef ADDER_SCHED_CARRY_EN
  localparam bit CarryEn = 1'b1;
`else
  localparam bit CarryEn = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid, req_ready;
  logic [8*NUM_REQ-1:0] req_a, req_b;
  logic [7:0]           add_a, add_b, add_sum;
  logic                 rsp_valid, rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_sum;
  logic                 rsp_carry, busy;

  always #5 clk = ~clk;

  // External adder.
  assign add_sum = add_a + add_b;

  adder_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: one op in flight; result visible 2 cycles after grant until accepted.
  int cyc = 0;
  bit m_busy = 1'b0;
  int m_grant_cyc = 0;
  int m_last = NUM_REQ - 1;
  int exp_id = 0, exp_sum = 0, exp_a = 0, exp_b = 0;
  bit exp_carry = 1'b0;

  // Grants observed on the DUT's req_ready.
  int g_id[$];
  int g_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int mdl_winner(input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      int i;
      i = (m_last + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_cycle();
    bit                 exp_rv;
    int                 w;
    logic [NUM_REQ-1:0] exp_rdy;
    exp_rv = m_busy && (cyc >= m_grant_cyc + 2);
    w = m_busy ? -1 : mdl_winner(req_valid);
    exp_rdy = (w >= 0) ? NUM_REQ'(1 << w) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("busy", 32'(busy), 32'(m_busy));
    check("add_a", 32'(add_a), exp_a);
    check("add_b", 32'(add_b), exp_b);
    if (exp_rv) begin
      check("rsp_id", 32'(rsp_id), exp_id);
      check("rsp_sum", 32'(rsp_sum), exp_sum);
      check("rsp_carry", 32'(rsp_carry), 32'(exp_carry));
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_ready[i]) begin
        g_id.push_back(i);
        g_cyc.push_back(cyc);
      end
    end
    if (w >= 0) begin
      m_busy = 1'b1;
      m_grant_cyc = cyc;
      m_last = w;
      exp_id = w;
      exp_a = int'((req_a >> (8 * w)) & 32'hFF);
      exp_b = int'((req_b >> (8 * w)) & 32'hFF);
      exp_sum = (exp_a + exp_b) % 256;
      exp_carry = CarryEn && ((exp_a + exp_b) > 255);
    end else if (exp_rv && rsp_ready) begin
      m_busy = 1'b0;
    end
    cyc++;
  endtask

  // One cycle: drive just after the rising edge, check on the falling edge.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic rdy);
    @(posedge clk);
    #1;
    req_valid = v;
    req_a = a;
    req_b = b;
    rsp_ready = rdy;
    @(negedge clk);
    check_cycle();
  endtask

  // Mid-cycle asynchronous reset held for one cycle, with requests pending.
  task automatic do_reset(input logic [NUM_REQ-1:0] v);
    @(posedge clk);
    #1;
    req_valid = v;
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    m_busy = 1'b0;
    m_last = NUM_REQ - 1;
    exp_a = 0;
    exp_b = 0;
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    do_reset(4'b1111);

    // Single op on requester 0.
    step(4'b0001, 32'h0000_0012, 32'h0000_0034, 1'b1);
    check("single_grant", 32'(req_ready), 32'h1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    check("single_wait", 32'(rsp_valid), 32'd0);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_sum", 32'(rsp_sum), 32'h46);
    check("single_id", 32'(rsp_id), 32'd0);

    // Wrap-around on requester 2.
    step(4'b0100, 32'h00FF_0000, 32'h0002_0000, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    check("wrap_sum", 32'(rsp_sum), 32'h01);
    check("wrap_carry", 32'(rsp_carry), 32'(CarryEn));

    // Pointer skip: after granting 1, {3,0} valid grants 3 first, then 0.
    step(4'b0010, $urandom, $urandom, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    step(4'b1001, $urandom, $urandom, 1'b1);
    check("skip_first", 32'(req_ready), 32'b1000);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    step(4'b1001, $urandom, $urandom, 1'b1);
    check("skip_second", 32'(req_ready), 32'b0001);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);

    // Backpressure: 5 stalled response cycles, then grant right after handshake.
    step(4'b0001, $urandom, $urandom, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, $urandom, $urandom, 1'b0);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_no_ready", 32'(req_ready), 32'd0);
    end
    step(4'b1111, $urandom, $urandom, 1'b1);
    step(4'b1111, $urandom, $urandom, 1'b1);
    check("bp_next_grant", 32'(req_ready), 32'b0010);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);

    // Reset in RESP discards the result; pointer returns to favour requester 0.
    step(4'b0010, $urandom, $urandom, 1'b0);
    step(4'b0000, 32'h0, 32'h0, 1'b0);
    step(4'b0000, 32'h0, 32'h0, 1'b0);
    check("resp_reached", 32'(rsp_valid), 32'd1);
    do_reset(4'b0011);
    step(4'b0011, $urandom, $urandom, 1'b1);
    check("rst_then_grant0", 32'(req_ready), 32'b0001);
    step(4'b0000, 32'h0, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 32'h0, 1'b1);

    // Round-robin fairness from reset with all requesters valid.
    do_reset(4'b0000);
    g_id.delete();
    g_cyc.delete();
    for (int i = 0; i < 15; i++) begin
      step(4'b1111, $urandom, $urandom, 1'b1);
    end
    check("rr_count", 32'(g_id.size()), 32'd5);
    for (int i = 0; i < 5 && i < g_id.size(); i++) begin
      check("rr_order", 32'(g_id[i]), 32'(i % 4));
      if (i > 0) check("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(NUM_REQ'($urandom), $urandom, $urandom, ($urandom % 4) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_sched.md
Name: adder_sched

Overview:
- Round-robin scheduler that shares one 8-bit `adder` datapath between NUM_REQ requesters.
- Sits between requester logic and the adder instance:
  - registers the winning request's operands onto the adder's a_in/b_in;
  - captures sum one cycle later;
  - returns the result with the requester ID over a valid/ready response channel.
- Only one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- wb_clk_i  input  1  single clock, rising edge
- wb_rst_ni  input  1  asynchronous reset, active low
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero
- req_a  input  8*NUM_REQ  packed operand A; requester i uses bits [8i+7:8i]
- req_b  input  8*NUM_REQ  packed operand B, same packing as req_a
- add_a  output  8  to adder a_in
- add_b  output  8  to adder b_in
- add_sum  input  8  from adder sum, combinational from add_a/add_b
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  ID_W  index of requester that issued the result
- rsp_sum  output  8  captured sum, mod 256
- rsp_carry  output  1  carry-out; see Optional Feature
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (wb_rst_ni low, asynchronous):
  - state=IDLE; add_a=0, add_b=0; rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0; busy=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority after reset.
  - req_ready=0 while reset is asserted.
- FSM states: IDLE, ADD, RESP.
- IDLE:
  - req_ready is combinational: one-hot on the winner, which is the first valid requester searching upward from last+1 and wrapping at NUM_REQ.
  - req_ready is all-zero when no request is valid.
  - Handshake (valid & ready): latch req_a/req_b of the winner into add_a/add_b, latch its index into rsp_id, set last=winner, go to ADD.
- ADD:
  - add_a/add_b are stable for the whole cycle.
  - At the end of the cycle, capture add_sum into rsp_sum (and carry if enabled), set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_sum and rsp_carry are held stable until rsp_ready=1.
  - On a cycle with rsp_valid & rsp_ready: rsp_valid=0, go to IDLE.
  - req_ready=0 in both ADD and RESP.
- Latency and throughput:
  - Request handshake to rsp_valid: 2 cycles.
  - Minimum spacing between grants: 3 cycles (rsp_ready held at 1).
- Arithmetic: 8-bit unsigned; wrap-around modulo 256; no saturation.
- add_a/add_b keep their last operands after an operation; they are not cleared.
- Requesters may drop req_valid before being granted; there is no penalty and the pointer does not change.
- Pointer updates only on a grant.
- With a single valid requester, that requester wins regardless of the pointer.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Reset asserted mid-operation (ADD or RESP): the result is discarded, all outputs return to reset values immediately, and the pointer is reset.
- Reset release is synchronised externally; the block needs no internal synchroniser.

Optional Feature:
- Macro: ADDER_SCHED_CARRY_EN.
- Defined:
  - In ADD, rsp_carry is captured as (a7&b7) | ((a7|b7) & ~s7), using the registered operand MSBs and add_sum[7].
  - rsp_carry is held with rsp_sum.
- Undefined:
  - The carry logic is not built.
  - rsp_carry is tied to 0 (the port remains present).

Test Plan:
- Reset mid-RESP:
  - Stimulus: grant requester 1, reach RESP, assert wb_rst_ni=0 for 1 cycle.
  - Response: rsp_valid=0 asynchronously, busy=0, state IDLE. A following simultaneous request from 0 and 1 grants 0.
- Single op:
  - Stimulus: req_valid=4'b0001, A=0x12, B=0x34, rsp_ready=1.
  - Response: req_ready=0001 at cycle 0; rsp_valid at cycle 2 with rsp_sum=0x46, rsp_id=0.
- Round-robin fairness:
  - Stimulus: all four requesters valid continuously, rsp_ready=1.
  - Response: grant order 0,1,2,3,0 at 3-cycle spacing.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid.
  - Response: rsp_sum/rsp_id stable, req_ready=0 throughout, busy=1. The next grant occurs the cycle after the handshake.
- Wrap-around:
  - Stimulus: A=0xFF, B=0x02.
  - Response: rsp_sum=0x01; rsp_carry=1 with ADDER_SCHED_CARRY_EN defined, 0 without.
- Pointer skip:
  - Stimulus: last grant was 1; valid=4'b1001.
  - Response: requester 3 granted before requester 0.
